// File: rtl/cpu_step_ctrl.sv
// Execution-enable sequencer for the CPU datapath: issues the one-cycle cpu_en strobe
// in free-run, single-step, or breakpoint/halt modes, and counts issued strobes.
module cpu_step_ctrl #(
    parameter int ADDR_W  = 6,
    parameter int RUN_DIV = 5_000_000,
    parameter int LOCKOUT = 5_000_000,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_mode,
    input  logic              step_key,
    input  logic              halt_req,
    input  logic              bp_en,
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic [ADDR_W-1:0] pc,
    output logic              cpu_en,
    output logic [1:0]        state,
    output logic              halted,
    output logic [CNT_W-1:0]  instr_count
);

    localparam int PRE_W  = $clog2(RUN_DIV);
    localparam int LOCK_W = (LOCKOUT > 1) ? $clog2(LOCKOUT) : 1;
    localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(RUN_DIV - 1);
    localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCKOUT - 1);

    typedef enum logic [1:0] {
        ST_STEP  = 2'd0,
        ST_LOCK  = 2'd1,
        ST_RUN   = 2'd2,
        ST_BREAK = 2'd3
    } state_t;

    logic              r_key_s1;
    logic              r_key_s2;
    logic              r_key_prev;
    logic [1:0]        r_arm_cnt;
    state_t            r_state;
    logic [PRE_W-1:0]  r_presc;
    logic [LOCK_W-1:0] r_lock;
    logic              r_cpu_en;
    logic              r_halted;
    logic [CNT_W-1:0]  r_count;

    logic              w_press;
    logic              w_tick;
    logic              w_bp_hit;
    logic              w_pulse;
    state_t            w_state_next;
    logic [PRE_W-1:0]  w_presc_next;
    logic [LOCK_W-1:0] w_lock_next;

    // The edge detector only arms once the synchronizer has flushed its reset value,
    // so a key held down through reset release never looks like a fresh press.
    assign w_press  = (r_arm_cnt == 2'd3) && r_key_prev && !r_key_s2;
    assign w_tick   = (r_presc == PRE_MAX);
    assign w_bp_hit = bp_en && (pc == bp_addr);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        w_state_next = r_state;
        w_pulse      = 1'b0;
        w_presc_next = '0;
        w_lock_next  = '0;
        case (r_state)
            ST_STEP: begin
                if (run_mode) begin
                    w_state_next = ST_RUN;
                end else if (w_press) begin
                    w_pulse      = 1'b1;
                    w_state_next = ST_LOCK;
                end
            end
            ST_LOCK: begin
                if (r_lock == LOCK_MAX) begin
                    w_state_next = run_mode ? ST_RUN : ST_STEP;
                end else begin
                    w_lock_next = r_lock + LOCK_W'(1);
                end
            end
            ST_RUN: begin
                if (!run_mode) begin
                    w_state_next = ST_STEP;
                end else if (halt_req) begin
                    w_state_next = ST_BREAK;
                end else if (w_tick) begin
                    if (w_bp_hit) w_state_next = ST_BREAK;
                    else          w_pulse      = 1'b1;
                end else begin
                    w_presc_next = r_presc + PRE_W'(1);
                end
            end
            ST_BREAK: begin
                if (w_press) begin
                    w_pulse      = 1'b1;
                    w_state_next = ST_LOCK;
                end else if (!run_mode) begin
                    w_state_next = ST_STEP;
                end
            end
            default: w_state_next = ST_STEP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_s1   <= 1'b1;
            r_key_s2   <= 1'b1;
            r_key_prev <= 1'b1;
            r_arm_cnt  <= 2'd0;
            r_state    <= ST_STEP;
            r_presc    <= '0;
            r_lock     <= '0;
            r_cpu_en   <= 1'b0;
            r_halted   <= 1'b0;
            r_count    <= '0;
        end else begin
            r_key_s1   <= step_key;
            r_key_s2   <= r_key_s1;
            r_key_prev <= r_key_s2;
            if (r_arm_cnt != 2'd3) r_arm_cnt <= r_arm_cnt + 2'd1;
            r_state    <= w_state_next;
            r_presc    <= w_presc_next;
            r_lock     <= w_lock_next;
            r_cpu_en   <= w_pulse;
            r_halted   <= (w_state_next == ST_BREAK);
            r_count    <= r_count + CNT_W'(w_pulse);
        end
    end

    assign cpu_en      = r_cpu_en;
    assign state       = r_state;
    assign halted      = r_halted;
    assign instr_count = r_count;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl with RUN_DIV = 4, LOCKOUT = 3 and a pc-increment datapath model.
module tb_cpu_step_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        run_mode;
    logic        step_key;
    logic        halt_req;
    logic        bp_en;
    logic [5:0]  bp_addr;
    logic [5:0]  pc;
    logic        cpu_en;
    logic [1:0]  state;
    logic        halted;
    logic [15:0] instr_count;

    int n_tests = 0;
    int n_fail  = 0;

    cpu_step_ctrl #(
        .ADDR_W (6),
        .RUN_DIV(4),
        .LOCKOUT(3),
        .CNT_W  (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run_mode   (run_mode),
        .step_key   (step_key),
        .halt_req   (halt_req),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .pc         (pc),
        .cpu_en     (cpu_en),
        .state      (state),
        .halted     (halted),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // Datapath model: the program counter advances on each cpu_en strobe.
    always @(posedge clk) begin
        if (rst)         pc <= 6'd0;
        else if (cpu_en) pc <= pc + 6'd1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; run_mode = 1'b0; step_key = 1'b1; halt_req = 1'b0;
        bp_en = 1'b0; bp_addr = 6'd0;
        tick(); tick();
        rst = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        int pulses = 0;
        rst = 1'b1; run_mode = 1'b0; step_key = 1'b0; halt_req = 1'b0;
        bp_en = 1'b0; bp_addr = 6'd0;
        repeat (3) tick();
        n_tests++;
        if (cpu_en !== 1'b0 || state !== 2'd0 || halted !== 1'b0 || instr_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_values: cpu_en=%0b state=%0d halted=%0b cnt=%0d want 0/0/0/0",
                     cpu_en, state, halted, instr_count);
        end
        rst = 1'b0;
        repeat (8) begin
            tick();
            if (cpu_en) pulses++;
        end
        n_tests++;
        if (pulses != 0 || state !== 2'd0) begin
            n_fail++;
            $display("FAIL held_key_through_reset: pulses=%0d state=%0d want 0/0", pulses, state);
        end
        step_key = 1'b1;
        repeat (4) tick();
    endtask

    task automatic test_single_step();
        halt_req = 1'b1;
        step_key = 1'b0;
        tick(); tick();
        n_tests++;
        if (cpu_en !== 1'b0) begin
            n_fail++;
            $display("FAIL step_early: cpu_en=%0b want 0 two cycles after key fall", cpu_en);
        end
        tick();
        n_tests++;
        if (cpu_en !== 1'b1 || instr_count !== 16'd1 || state !== 2'd1) begin
            n_fail++;
            $display("FAIL step_pulse: cpu_en=%0b cnt=%0d state=%0d want 1/1/1", cpu_en, instr_count, state);
        end
        tick(); tick();
        n_tests++;
        if (cpu_en !== 1'b0 || state !== 2'd1) begin
            n_fail++;
            $display("FAIL step_lock: cpu_en=%0b state=%0d want 0/1", cpu_en, state);
        end
        tick();
        n_tests++;
        if (state !== 2'd0 || instr_count !== 16'd1) begin
            n_fail++;
            $display("FAIL step_unlock: state=%0d cnt=%0d want 0/1", state, instr_count);
        end
        halt_req = 1'b0;
        step_key = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_double_press();
        int pulses = 0;
        do_reset();
        step_key = 1'b0; tick();
        step_key = 1'b1; tick();
        step_key = 1'b0; tick();
        if (cpu_en) pulses++;
        step_key = 1'b1;
        repeat (10) begin
            tick();
            if (cpu_en) pulses++;
        end
        n_tests++;
        if (pulses != 1 || instr_count !== 16'd1 || state !== 2'd0) begin
            n_fail++;
            $display("FAIL double_press: pulses=%0d cnt=%0d state=%0d want 1/1/0", pulses, instr_count, state);
        end
    endtask

    task automatic test_free_run();
        int pulses = 0;
        int bad = 0;
        do_reset();
        run_mode = 1'b1;
        tick();
        n_tests++;
        if (state !== 2'd2) begin
            n_fail++;
            $display("FAIL run_entry: state=%0d want 2", state);
        end
        for (int i = 1; i <= 256; i++) begin
            tick();
            if (cpu_en) begin
                pulses++;
                if ((i % 4) != 0 || pc !== 6'(pulses - 1)) bad++;
            end
        end
        n_tests++;
        if (pulses != 64 || bad != 0 || instr_count !== 16'd64) begin
            n_fail++;
            $display("FAIL free_run: pulses=%0d bad=%0d cnt=%0d want 64/0/64", pulses, bad, instr_count);
        end
        tick();
        n_tests++;
        if (pc !== 6'd0 || cpu_en !== 1'b0) begin
            n_fail++;
            $display("FAIL pc_wrap: pc=%0d cpu_en=%0b want 0/0", pc, cpu_en);
        end
    endtask

    task automatic test_breakpoint();
        int pulses = 0;
        int later = 0;
        int guard = 0;
        int first = 0;
        do_reset();
        bp_en = 1'b1; bp_addr = 6'd5; run_mode = 1'b1;
        while (state !== 2'd3 && guard < 200) begin
            tick();
            guard++;
            if (cpu_en) pulses++;
        end
        n_tests++;
        if (state !== 2'd3 || halted !== 1'b1 || pulses != 5 || pc !== 6'd5) begin
            n_fail++;
            $display("FAIL bp_stop: state=%0d halted=%0b pulses=%0d pc=%0d want 3/1/5/5",
                     state, halted, pulses, pc);
        end
        repeat (50) begin
            tick();
            if (cpu_en) later++;
        end
        n_tests++;
        if (later != 0 || state !== 2'd3) begin
            n_fail++;
            $display("FAIL bp_hold: pulses=%0d state=%0d want 0/3", later, state);
        end
        step_key = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (cpu_en !== 1'b1 || state !== 2'd1 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_step: cpu_en=%0b state=%0d halted=%0b want 1/1/0", cpu_en, state, halted);
        end
        tick();
        n_tests++;
        if (pc !== 6'd6) begin
            n_fail++;
            $display("FAIL bp_step_pc: pc=%0d want 6", pc);
        end
        tick(); tick();
        n_tests++;
        if (state !== 2'd2) begin
            n_fail++;
            $display("FAIL bp_resume: state=%0d want 2", state);
        end
        for (int j = 1; j <= 8; j++) begin
            tick();
            if (cpu_en && first == 0) first = j;
        end
        n_tests++;
        if (first != 4) begin
            n_fail++;
            $display("FAIL bp_resume_pulse: first pulse at cycle %0d want 4", first);
        end
        step_key = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_halt_on_tick();
        do_reset();
        bp_en = 1'b1; bp_addr = 6'd0; run_mode = 1'b1;
        repeat (4) tick();
        halt_req = 1'b1;
        tick();
        n_tests++;
        if (cpu_en !== 1'b0 || state !== 2'd3 || halted !== 1'b1 || instr_count !== 16'd0) begin
            n_fail++;
            $display("FAIL halt_tick: cpu_en=%0b state=%0d halted=%0b cnt=%0d want 0/3/1/0",
                     cpu_en, state, halted, instr_count);
        end
        halt_req = 1'b0;
        run_mode = 1'b0;
        tick();
        n_tests++;
        if (state !== 2'd0 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL break_exit: state=%0d halted=%0b want 0/0", state, halted);
        end
    endtask

    task automatic test_reset_midop();
        do_reset();
        step_key = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        n_tests++;
        if (cpu_en !== 1'b0 || instr_count !== 16'd0 || state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_pending: cpu_en=%0b cnt=%0d state=%0d want 0/0/0", cpu_en, instr_count, state);
        end
        rst = 1'b0;
        step_key = 1'b1;
        repeat (4) tick();
        step_key = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        n_tests++;
        if (cpu_en !== 1'b0 || instr_count !== 16'd0 || state !== 2'd0 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_lock: cpu_en=%0b cnt=%0d state=%0d halted=%0b want 0/0/0/0",
                     cpu_en, instr_count, state, halted);
        end
        rst = 1'b0;
        step_key = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_double_press();
        test_free_run();
        test_breakpoint();
        test_halt_on_tick();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
